// File: rtl/fetch_if.sv
// fetch_if: PC owner and single-outstanding imem requester feeding a 2-entry {instr, pc} queue
module fetch_if #(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ctrl_i_fetch_stall,
    input  logic        ctrl_i_fetch_flush,
    input  logic [31:0] ctrl_i_redirect_pc,
    output logic        imem_o_req,
    output logic [31:0] imem_o_addr,
    input  logic        imem_i_ready,
    input  logic        imem_i_rvalid,
    input  logic [31:0] imem_i_rdata,
    output logic [31:0] fetch_o_instr,
    output logic [31:0] fetch_o_pc,
    output logic [31:0] fetch_o_pre_pc,
    output logic        fetch_o_commit
);
    logic [31:0] pc_q, req_pc_q;
    logic        outstanding_q, drop_q;
    logic [31:0] instr_q [2];
    logic [31:0] ipc_q [2];
    logic        rd_q, wr_q;
    logic [1:0]  count_q;
    logic        accept, push, pop;

    // Only one request in flight; a queue slot is reserved at issue time
    assign imem_o_req  = rst_n & ~outstanding_q & (count_q != 2'd2) & ~ctrl_i_fetch_flush;
    assign imem_o_addr = pc_q;
    assign accept      = imem_o_req & imem_i_ready;
    assign push        = imem_i_rvalid & outstanding_q & ~drop_q & ~ctrl_i_fetch_flush;
    assign pop         = fetch_o_commit & ~ctrl_i_fetch_stall & ~ctrl_i_fetch_flush;

    assign fetch_o_commit = count_q != 2'd0;
    assign fetch_o_instr  = fetch_o_commit ? instr_q[rd_q] : NOP_INSTR;
    assign fetch_o_pc     = fetch_o_commit ? ipc_q[rd_q] : 32'd0;
    assign fetch_o_pre_pc = fetch_o_commit ? ipc_q[rd_q] + 32'd4 : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            req_pc_q      <= 32'd0;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            rd_q          <= 1'b0;
            wr_q          <= 1'b0;
            count_q       <= 2'd0;
        end else begin
            if (ctrl_i_fetch_flush) begin
                pc_q    <= ctrl_i_redirect_pc;
                rd_q    <= 1'b0;
                wr_q    <= 1'b0;
                count_q <= 2'd0;
            end else begin
                if (accept) pc_q <= pc_q + 32'd4;
                if (push) wr_q <= ~wr_q;
                if (pop) rd_q <= ~rd_q;
                count_q <= count_q + 2'(push) - 2'(pop);
            end
            if (accept) req_pc_q <= pc_q;
            if (accept) outstanding_q <= 1'b1;
            else if (imem_i_rvalid) outstanding_q <= 1'b0;
            // A flush with a response still pending arms discard of that response
            drop_q <= (drop_q | (ctrl_i_fetch_flush & outstanding_q)) & ~imem_i_rvalid;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_q] <= imem_i_rdata;
            ipc_q[wr_q]   <= req_pc_q;
        end
    end
endmodule

// File: tb/tb_fetch_if.sv
// tb_fetch_if: cycle-by-cycle directed vectors for fetch_if plus async-reset sequence
module tb_fetch_if;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] I0 = 32'h00A0_0093, I1 = 32'h0010_0113, I2 = 32'hDEAD_0013;
    localparam logic [31:0] I3 = 32'h0020_0193, I4 = 32'hBAD0_0013, I5 = 32'h0030_0213;
    localparam logic [31:0] I6 = 32'h0040_0293;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        stall = 1'b0, flush = 1'b0, ready = 1'b0, rvalid = 1'b0;
    logic [31:0] rpc = 32'd0, rdata = 32'd0;
    logic        req, commit;
    logic [31:0] addr, instr, pc, pre_pc;
    int          n_chk = 0, n_fail = 0;
    bit          pend = 1'b0;

    fetch_if dut (
        .clk(clk), .rst_n(rst_n),
        .ctrl_i_fetch_stall(stall), .ctrl_i_fetch_flush(flush), .ctrl_i_redirect_pc(rpc),
        .imem_o_req(req), .imem_o_addr(addr), .imem_i_ready(ready),
        .imem_i_rvalid(rvalid), .imem_i_rdata(rdata),
        .fetch_o_instr(instr), .fetch_o_pc(pc), .fetch_o_pre_pc(pre_pc), .fetch_o_commit(commit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall, flush;
        logic [31:0] rpc;
        logic        rvalid;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        commit;
        logic [31:0] instr, pc, pre;
    } vec_t;

    vec_t v[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic r, input logic [31:0] a, input logic c,
                           input logic [31:0] i, input logic [31:0] p, input logic [31:0] pp);
        chk({tag, " req"}, 32'(req), 32'(r));
        chk({tag, " addr"}, addr, a);
        chk({tag, " commit"}, 32'(commit), 32'(c));
        chk({tag, " instr"}, instr, i);
        chk({tag, " pc"}, pc, p);
        chk({tag, " pre_pc"}, pre_pc, pp);
    endtask

    initial begin
        //        stall flush rpc           rvalid rdata | req addr          commit instr pc            pre
        v.push_back('{0, 0, 32'd0,         0, 32'd0, 1, 32'h8000_0000, 0, NOP, 32'd0, 32'd0});
        v.push_back('{0, 0, 32'd0,         1, I0,    0, 32'h8000_0004, 0, NOP, 32'd0, 32'd0});
        v.push_back('{1, 0, 32'd0,         0, 32'd0, 1, 32'h8000_0004, 1, I0, 32'h8000_0000, 32'h8000_0004});
        v.push_back('{1, 0, 32'd0,         1, I1,    0, 32'h8000_0008, 1, I0, 32'h8000_0000, 32'h8000_0004});
        for (int k = 0; k < 4; k++)
            v.push_back('{1, 0, 32'd0,     0, 32'd0, 0, 32'h8000_0008, 1, I0, 32'h8000_0000, 32'h8000_0004});
        v.push_back('{0, 0, 32'd0,         0, 32'd0, 0, 32'h8000_0008, 1, I0, 32'h8000_0000, 32'h8000_0004});
        v.push_back('{0, 0, 32'd0,         0, 32'd0, 1, 32'h8000_0008, 1, I1, 32'h8000_0004, 32'h8000_0008});
        v.push_back('{0, 1, 32'h8000_0100, 0, 32'd0, 0, 32'h8000_000C, 0, NOP, 32'd0, 32'd0});
        v.push_back('{0, 0, 32'd0,         0, 32'd0, 0, 32'h8000_0100, 0, NOP, 32'd0, 32'd0});
        v.push_back('{0, 0, 32'd0,         0, 32'd0, 0, 32'h8000_0100, 0, NOP, 32'd0, 32'd0});
        v.push_back('{0, 0, 32'd0,         1, I2,    0, 32'h8000_0100, 0, NOP, 32'd0, 32'd0});
        v.push_back('{0, 0, 32'd0,         0, 32'd0, 1, 32'h8000_0100, 0, NOP, 32'd0, 32'd0});
        v.push_back('{0, 0, 32'd0,         1, I3,    0, 32'h8000_0104, 0, NOP, 32'd0, 32'd0});
        v.push_back('{1, 0, 32'd0,         0, 32'd0, 1, 32'h8000_0104, 1, I3, 32'h8000_0100, 32'h8000_0104});
        v.push_back('{1, 1, 32'hFFFF_FFFC, 1, I4,    0, 32'h8000_0108, 1, I3, 32'h8000_0100, 32'h8000_0104});
        v.push_back('{0, 0, 32'd0,         0, 32'd0, 1, 32'hFFFF_FFFC, 0, NOP, 32'd0, 32'd0});
        v.push_back('{0, 0, 32'd0,         1, I5,    0, 32'h0000_0000, 0, NOP, 32'd0, 32'd0});
        v.push_back('{1, 0, 32'd0,         0, 32'd0, 1, 32'h0000_0000, 1, I5, 32'hFFFF_FFFC, 32'h0000_0000});
        v.push_back('{1, 0, 32'd0,         1, I6,    0, 32'h0000_0004, 1, I5, 32'hFFFF_FFFC, 32'h0000_0000});
        v.push_back('{1, 0, 32'd0,         0, 32'd0, 0, 32'h0000_0004, 1, I5, 32'hFFFF_FFFC, 32'h0000_0000});

        repeat (2) @(negedge clk);
        #1 chk_out("reset", 1'b0, 32'h8000_0000, 1'b0, NOP, 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b1;
        for (int k = 0; k < v.size(); k++) begin
            if (k > 0) @(negedge clk);
            stall = v[k].stall; flush = v[k].flush; rpc = v[k].rpc;
            rvalid = v[k].rvalid; rdata = v[k].rdata;
            #1;
            if (rvalid) chk($sformatf("c%0d rvalid_protocol", k), 32'(pend), 32'd1);
            chk_out($sformatf("c%0d", k), v[k].req, v[k].addr, v[k].commit, v[k].instr, v[k].pc, v[k].pre);
            if (v[k].commit) chk($sformatf("c%0d no_stale_pc", k), 32'(pc == 32'h8000_0008), 32'd0);
            @(posedge clk);
            if (rvalid) pend = 1'b0;
            if (req && ready) pend = 1'b1;
        end

        // Async reset mid-stall with the queue full: outputs clear before any clock edge
        #2 rst_n = 1'b0;
        #1 chk_out("async_rst", 1'b0, 32'h8000_0000, 1'b0, NOP, 32'd0, 32'd0);
        @(negedge clk);
        stall = 1'b0;
        rst_n = 1'b1;
        #1 chk_out("post_rst", 1'b1, 32'h8000_0000, 1'b0, NOP, 32'd0, 32'd0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
